banco_registradores_multi: RTL and testbench

Parametrised successor to the processor's register bank: a `2**ADDR_W`-entry, `DATA_W`-bit register file with `N_READ` combinational read ports and optional write-to-read bypass. It adds a dedicated stack-pointer unit with push, pop and load operations, bounds checking, and sticky overflow/underflow flags. It also has a JAL link-register write path. It sits in the decode stage, between the instruction decoder/control unit and the ALU operand muxes.

---
 rtl/banco_pkg.sv | 16 +
 rtl/banco_registradores_multi_sp_unit.sv | 85 ++++++++
 rtl/banco_registradores_multi.sv | 133 +++++++++++++
 tb/tb_banco_registradores_multi.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/banco_pkg.sv
// Shared types and default constants for the multi-port register bank.
// Exports stack_op_e (StackOP encoding) and default SP/RA indices and step.
package banco_pkg;

    typedef enum logic [1:0] {
        SOP_NONE = 2'b00,
        SOP_PUSH = 2'b01,
        SOP_POP  = 2'b10,
        SOP_LOAD = 2'b11
    } stack_op_e;

    localparam int SP_IDX_DEF     = 29;
    localparam int RA_IDX_DEF     = 31;
    localparam int STACK_STEP_DEF = 4;

endpackage

// File: rtl/banco_registradores_multi_sp_unit.sv
// Stack-pointer register with push/pop bounds checking and sticky flags.
// Ports: clock/reset, op_en/op/sp_in (stack op), wr_en/wr_data (plain
// load when op is none), sp_next (value after this edge), sp, ovf, unf.
module sp_unit
    import banco_pkg::*;
#(
    parameter int                 DATA_W     = 32,
    parameter logic [DATA_W-1:0]  SP_RESET   = 32'h0000_03FC,
    parameter logic [DATA_W-1:0]  SP_MIN     = 32'h0000_0000,
    parameter logic [DATA_W-1:0]  SP_MAX     = 32'h0000_03FC,
    parameter int                 STACK_STEP = STACK_STEP_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              op_en,
    input  stack_op_e         op,
    input  logic [DATA_W-1:0] sp_in,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] sp_next,
    output logic [DATA_W-1:0] sp,
    output logic              ovf,
    output logic              unf
);

    // One extra bit keeps the borrow/carry of the bounds arithmetic.
    localparam logic [DATA_W:0] STEP_X   = (DATA_W+1)'(STACK_STEP);
    localparam logic [DATA_W:0] SP_MIN_X = {1'b0, SP_MIN};
    localparam logic [DATA_W:0] SP_MAX_X = {1'b0, SP_MAX};

    logic [DATA_W-1:0] sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [DATA_W:0] push_diff;
    logic [DATA_W:0] pop_sum;
    logic            push_err;
    logic            pop_err;

    assign push_diff = {1'b0, sp_q} - STEP_X;
    assign pop_sum   = {1'b0, sp_q} + STEP_X;
    // A borrow wraps push_diff high, so it is an error on its own.
    assign push_err  = push_diff[DATA_W] || (push_diff < SP_MIN_X);
    assign pop_err   = pop_sum > SP_MAX_X;

    always_comb begin
        sp_d  = sp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (op_en) begin
            unique case (op)
                SOP_PUSH: begin
                    if (push_err) ovf_d = 1'b1;
                    else          sp_d  = push_diff[DATA_W-1:0];
                end
                SOP_POP: begin
                    if (pop_err) unf_d = 1'b1;
                    else         sp_d  = pop_sum[DATA_W-1:0];
                end
                SOP_LOAD: sp_d = sp_in;
                SOP_NONE: begin
                    if (wr_en) sp_d = wr_data;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sp_q  <= SP_RESET;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign sp_next = sp_d;
    assign sp      = sp_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

endmodule

// File: rtl/banco_registradores_multi.sv
// Decode-stage register file: N_READ combinational ports, optional bypass,
// JAL link write and a bounded stack pointer held in sp_unit.
// Ports: clock/reset, RAddr/RData (packed per port), RegWrite/NOP/RD/
// DadoEscrito, JAL/PCLink, StackOP/SPIn, SPOut, StackOvf/StackUnf.
module banco_registradores_multi
    import banco_pkg::*;
#(
    parameter int                 DATA_W     = 32,
    parameter int                 ADDR_W     = 6,
    parameter int                 N_READ     = 2,
    parameter int                 BYPASS     = 1,
    parameter int                 SP_IDX     = SP_IDX_DEF,
    parameter int                 RA_IDX     = RA_IDX_DEF,
    parameter logic [DATA_W-1:0]  SP_RESET   = 32'h0000_03FC,
    parameter logic [DATA_W-1:0]  SP_MIN     = 32'h0000_0000,
    parameter logic [DATA_W-1:0]  SP_MAX     = 32'h0000_03FC,
    parameter int                 STACK_STEP = STACK_STEP_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_READ*ADDR_W-1:0]   RAddr,
    output logic [N_READ*DATA_W-1:0]   RData,
    input  logic                       RegWrite,
    input  logic                       NOP,
    input  logic [ADDR_W-1:0]          RD,
    input  logic [DATA_W-1:0]          DadoEscrito,
    input  logic                       JAL,
    input  logic [DATA_W-1:0]          PCLink,
    input  logic [1:0]                 StackOP,
    input  logic [DATA_W-1:0]          SPIn,
    output logic [DATA_W-1:0]          SPOut,
    output logic                       StackOvf,
    output logic                       StackUnf
);

    localparam int                N_REG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] SP_A  = ADDR_W'(SP_IDX);
    localparam logic [ADDR_W-1:0] RA_A  = ADDR_W'(RA_IDX);

    logic [DATA_W-1:0] regs_q [N_REG];
    logic [DATA_W-1:0] regs_d [N_REG];

    stack_op_e         sop;
    logic              wr_ok;
    logic              gen_we;
    logic              jal_we;
    logic              sp_wr_jal;
    logic              sp_wr_en;
    logic [DATA_W-1:0] sp_wr_data;
    logic [DATA_W-1:0] sp_next;
    logic [DATA_W-1:0] sp_cur;

    assign sop   = stack_op_e'(StackOP);
    assign wr_ok = !NOP;

    // The SP slot of the array is never used; SP lives in sp_unit.
    assign gen_we = wr_ok && RegWrite
                 && (RD != '0) && (RD != SP_A);
    assign jal_we = wr_ok && JAL
                 && (RA_A != '0) && (RA_A != SP_A);

    // Plain SP loads only happen with no stack op; sp_unit enforces it.
    // With RA aliased onto SP, the JAL data beats the general write.
    assign sp_wr_jal  = wr_ok && JAL && (RA_A == SP_A);
    assign sp_wr_en   = sp_wr_jal
                     || (wr_ok && RegWrite && (RD == SP_A));
    assign sp_wr_data = sp_wr_jal ? PCLink : DadoEscrito;

    sp_unit #(
        .DATA_W     (DATA_W),
        .SP_RESET   (SP_RESET),
        .SP_MIN     (SP_MIN),
        .SP_MAX     (SP_MAX),
        .STACK_STEP (STACK_STEP)
    ) u_sp (
        .clock   (clock),
        .reset   (reset),
        .op_en   (wr_ok),
        .op      (sop),
        .sp_in   (SPIn),
        .wr_en   (sp_wr_en),
        .wr_data (sp_wr_data),
        .sp_next (sp_next),
        .sp      (sp_cur),
        .ovf     (StackOvf),
        .unf     (StackUnf)
    );

    // JAL is applied last so it beats a general write to RA.
    always_comb begin
        regs_d = regs_q;
        if (gen_we) regs_d[RD]   = DadoEscrito;
        if (jal_we) regs_d[RA_A] = PCLink;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_REG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    for (genvar k = 0; k < N_READ; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdata;

        assign ra = RAddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rdata = regs_q[ra];
            if (ra == '0) begin
                rdata = '0;
            end else if (ra == SP_A) begin
                // sp_next equals the current SP when nothing changes it.
                rdata = (BYPASS != 0) ? sp_next : sp_cur;
            end else if ((BYPASS != 0) && jal_we && (ra == RA_A)) begin
                rdata = PCLink;
            end else if ((BYPASS != 0) && gen_we && (ra == RD)) begin
                rdata = DadoEscrito;
            end
        end

        assign RData[k*DATA_W +: DATA_W] = rdata;
    end

    assign SPOut = sp_cur;

endmodule

// File: tb/tb_banco_registradores_multi.sv
// Randomized self-checking bench for banco_registradores_multi.
// Reference model: register array plus SP/flags computed from plain rules.
module tb_banco_registradores_multi;

    logic        clock;
    logic        reset;
    logic [11:0] RAddr;
    logic [63:0] RData;
    logic        RegWrite;
    logic        NOP;
    logic [5:0]  RD;
    logic [31:0] DadoEscrito;
    logic        JAL;
    logic [31:0] PCLink;
    logic [1:0]  StackOP;
    logic [31:0] SPIn;
    logic [31:0] SPOut;
    logic        StackOvf;
    logic        StackUnf;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_r [64];
    logic [31:0] n_r [64];
    logic [31:0] m_sp, n_sp;
    logic        m_ovf, n_ovf, m_unf, n_unf;
    bit          m_valid = 0;

    banco_registradores_multi dut (
        .clock       (clock),
        .reset       (reset),
        .RAddr       (RAddr),
        .RData       (RData),
        .RegWrite    (RegWrite),
        .NOP         (NOP),
        .RD          (RD),
        .DadoEscrito (DadoEscrito),
        .JAL         (JAL),
        .PCLink      (PCLink),
        .StackOP     (StackOP),
        .SPIn        (SPIn),
        .SPOut       (SPOut),
        .StackOvf    (StackOvf),
        .StackUnf    (StackUnf)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Next architectural state from the behavioural rules.
    task automatic model_next();
        n_r   = m_r;
        n_sp  = m_sp;
        n_ovf = m_ovf;
        n_unf = m_unf;
        if (reset) begin
            for (int i = 0; i < 64; i++) n_r[i] = 0;
            n_sp  = 32'h3FC;
            n_ovf = 0;
            n_unf = 0;
        end else if (!NOP) begin
            case (StackOP)
                2'd1: begin
                    if (longint'(m_sp) - 4 < 0) n_ovf = 1;
                    else n_sp = m_sp - 4;
                end
                2'd2: begin
                    if (longint'(m_sp) + 4 > 64'h3FC) n_unf = 1;
                    else n_sp = m_sp + 4;
                end
                2'd3: n_sp = SPIn;
                default: if (RegWrite && RD == 29) n_sp = DadoEscrito;
            endcase
            if (RegWrite && RD != 0 && RD != 29) n_r[RD] = DadoEscrito;
            if (JAL) n_r[31] = PCLink;
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [5:0] a);
        if (a == 0)  return 32'h0;
        if (a == 29) return n_sp;
        return n_r[a];
    endfunction

    task automatic tick();
        logic [5:0] a;
        @(negedge clock);
        model_next();
        if (m_valid) begin
            check("spout", SPOut, m_sp);
            check("ovf", {31'b0, StackOvf}, {31'b0, m_ovf});
            check("unf", {31'b0, StackUnf}, {31'b0, m_unf});
            if (!reset) begin
                for (int k = 0; k < 2; k++) begin
                    a = RAddr[k*6 +: 6];
                    check($sformatf("rd%0d_r%0d", k, a),
                          RData[k*32 +: 32], exp_read(a));
                end
            end
        end
        @(posedge clock);
        #1;
        m_r   = n_r;
        m_sp  = n_sp;
        m_ovf = n_ovf;
        m_unf = n_unf;
        if (reset) m_valid = 1;
    endtask

    task automatic idle();
        reset = 0; RegWrite = 0; NOP = 0; RD = 0;
        DadoEscrito = 0; JAL = 0; PCLink = 0;
        StackOP = 0; SPIn = 0; RAddr = 0;
    endtask

    function automatic logic [5:0] pick_addr();
        case ($urandom_range(0, 5))
            0: return 6'd0;
            1: return 6'd3;
            2: return 6'd5;
            3: return 6'd29;
            4: return 6'd31;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    function automatic logic [31:0] pick_sp();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'h4;
            2: return 32'h3F8;
            3: return 32'h3FC;
            default: return 32'($urandom_range(0, 32'h500)) & ~32'h3;
        endcase
    endfunction

    initial begin
        idle();
        reset = 1;
        tick();
        reset = 0;
        check("rst_sp", SPOut, 32'h3FC);
        check("rst_ovf", {31'b0, StackOvf}, 32'h0);
        check("rst_unf", {31'b0, StackUnf}, 32'h0);

        // write r3 with same-cycle bypass read
        RegWrite = 1; RD = 3; DadoEscrito = 7; RAddr = {6'd0, 6'd3};
        #1 check("byp_r3", RData[31:0], 32'h7);
        tick();
        // write to r0 is dropped
        RD = 0; DadoEscrito = 32'hFFFF_FFFF; RAddr = {6'd3, 6'd0};
        tick();
        idle(); RAddr = {6'd3, 6'd0};
        #1 check("r0_zero", RData[31:0], 32'h0);
        check("r3_held", RData[63:32], 32'h7);
        // NOP suppresses the write
        NOP = 1; RegWrite = 1; RD = 5; DadoEscrito = 32'h55;
        tick();
        idle(); RAddr = {6'd0, 6'd5};
        #1 check("nop_r5", RData[31:0], 32'h0);
        // JAL beats the general write to r31
        JAL = 1; PCLink = 32'h40; RegWrite = 1; RD = 31; DadoEscrito = 9;
        tick();
        idle(); RAddr = {6'd0, 6'd31};
        #1 check("jal_r31", RData[31:0], 32'h40);

        // push x2, pop x3
        StackOP = 2'd1;
        tick(); tick();
        check("push2", SPOut, 32'h3F4);
        StackOP = 2'd2;
        tick();
        check("pop1", SPOut, 32'h3F8);
        tick();
        check("pop2", SPOut, 32'h3FC);
        check("pop2_unf", {31'b0, StackUnf}, 32'h0);
        tick();
        check("pop3", SPOut, 32'h3FC);
        check("pop3_unf", {31'b0, StackUnf}, 32'h1);
        StackOP = 2'd1;
        tick();
        check("push_after", SPOut, 32'h3F8);
        check("unf_sticky", {31'b0, StackUnf}, 32'h1);

        // load 4, push to 0, push overflow
        StackOP = 2'd3; SPIn = 32'h4;
        tick();
        StackOP = 2'd1;
        tick();
        check("push_to0", SPOut, 32'h0);
        tick();
        check("ovf_sp", SPOut, 32'h0);
        check("ovf_set", {31'b0, StackOvf}, 32'h1);
        reset = 1;
        tick();
        idle();
        check("rst2_sp", SPOut, 32'h3FC);
        check("rst2_flags", {30'b0, StackOvf, StackUnf}, 32'h0);

        // push beats general write to SP; bypass shows new SP
        StackOP = 2'd1; RegWrite = 1; RD = 29;
        DadoEscrito = 32'h123; RAddr = {6'd0, 6'd29};
        #1 check("byp_sp", RData[31:0], 32'h3F8);
        tick();
        check("push_wins", SPOut, 32'h3F8);
        idle();

        // plain write to SP with no stack op
        RegWrite = 1; RD = 29; DadoEscrito = 32'h100;
        tick();
        idle();
        check("sp_gen_wr", SPOut, 32'h100);

        for (int i = 0; i < 2000; i++) begin
            reset       = ($urandom_range(0, 59) == 0);
            NOP         = ($urandom_range(0, 7) == 0);
            RegWrite    = 1'($urandom_range(0, 1));
            RD          = pick_addr();
            DadoEscrito = $urandom;
            JAL         = ($urandom_range(0, 3) == 0);
            PCLink      = $urandom;
            StackOP     = 2'($urandom_range(0, 3));
            SPIn        = pick_sp();
            RAddr       = {pick_addr(), pick_addr()};
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
